// File: rtl/cla_seq_adder32.sv
// Sequential add/subtract unit: one 4-bit carry-lookahead slice is reused
// over WIDTH/4 cycles, LSB nibble first, with a single carry register between cycles.
module cla_seq_adder32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NIB = WIDTH / 4;
   localparam int KW  = $clog2(NIB);
   localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Returns {carry into bit 3, carry out, sum[3:0]} of one lookahead slice.
   function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
      logic [3:0] p;
      logic [3:0] g;
      logic [4:0] c;
      logic       bp;
      logic       bg;
      p    = x ^ y;
      g    = x & y;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      bp   = &p;
      bg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      c[4] = bg | (bp & c0);
      return {c[3], c[4], p ^ c[3:0]};
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
   logic [KW-1:0]    k_q, k_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [5:0]       slice_s;

   assign slice_s = cla4(a_q[3:0], b_q[3:0], carry_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN; else state_d = IDLE;
         RUN:     if (k_q == K_LAST) state_d = DONE; else state_d = RUN;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // busy/done are registered from the next state so they line up with state_q.
   always_comb begin
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         k_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   // Operands shift right one nibble per cycle; result nibbles enter from the top,
   // so after the last slice res_d holds the full result in place.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sum_d   = sum_q;
      k_d     = k_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b ^ {WIDTH{sub}};
               carry_d = sub | cin;
               k_d     = '0;
            end else begin
               k_d = k_q;
            end
         end
         RUN: begin
            a_d     = {4'b0000, a_q[WIDTH-1:4]};
            b_d     = {4'b0000, b_q[WIDTH-1:4]};
            res_d   = {slice_s[3:0], res_q[WIDTH-1:4]};
            carry_d = slice_s[4];
            k_d     = k_q + KW'(1);
            if (k_q == K_LAST) begin
               sum_d  = res_d;
               cout_d = slice_s[4];
               ovf_d  = slice_s[5] ^ slice_s[4];
               zero_d = (res_d == '0);
            end else begin
               sum_d = sum_q;
            end
         end
         DONE:    k_d = k_q;
         default: k_d = k_q;
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_cla_seq_adder32.sv
// Directed and randomised checks of cla_seq_adder32 (WIDTH=32): results,
// latency, start-ignore, mid-run reset and done spacing.
module tb_cla_seq_adder32;

   logic        clk, rst, start, sub, cin;
   logic [31:0] a, b;
   logic        busy, done, cout, ovf, zero;
   logic [31:0] sum;

   int     checks   = 0;
   int     failures = 0;
   longint cyc      = 0;
   longint last_done = -1;

   cla_seq_adder32 #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sub(sub), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issues one operation, scrambles the inputs after acceptance and checks the result.
   task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic ts, input logic tc, input logic [31:0] es,
                         input logic ec, input logic eo, input logic ez);
      int n;
      bit ok;
      a = ta; b = tb_; sub = ts; cin = tc; start = 1'b1;
      ok = 1'b0;
      for (n = 0; n < 5 && !ok; n++) begin
         @(posedge clk); #1;
         if (busy) ok = 1'b1;
      end
      start = 1'b0; a = $urandom; b = $urandom; sub = ~ts; cin = ~tc;
      chk({tag, " accept"}, 64'(ok), 64'd1);
      if (!ok) return;
      ok = 1'b0; n = 0;
      while (!ok && n < 20) begin
         @(posedge clk); #1; n++;
         if (done) ok = 1'b1;
      end
      chk({tag, " latency"}, 64'(n), 64'd8);
      if (ok) begin
         if (last_done >= 0) chk({tag, " spacing>=10"}, 64'(cyc - last_done >= 10), 64'd1);
         last_done = cyc;
         chk({tag, " sum"},  64'(sum),  64'(es));
         chk({tag, " cout"}, 64'(cout), 64'(ec));
         chk({tag, " ovf"},  64'(ovf),  64'(eo));
         chk({tag, " zero"}, 64'(zero), 64'(ez));
         chk({tag, " busy"}, 64'(busy), 64'd1);
      end
   endtask

   initial begin
      int busy_cnt, done_cnt;
      logic [31:0] ra, rb, bx, es;
      logic        rs, rc, ec, eo;
      logic [32:0] wide;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst sum",  64'(sum),  64'd0);
      chk("rst cout", 64'(cout), 64'd0);
      chk("rst ovf",  64'(ovf),  64'd0);
      chk("rst zero", 64'(zero), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op("ffff+1",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
      run_op("5-7",      32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
      run_op("max+1",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
      run_op("min-1",    32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
      run_op("add cin",  32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h2345678A, 1'b0, 1'b0, 1'b0);
      run_op("3-3",      32'h00000003, 32'h00000003, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
      run_op("sub cin1", 32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0);
      run_op("0+0+1",    32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0);
      run_op("min+min",  32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1);
      run_op("min-1 b",  32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);

      // Second start three cycles into a run must be ignored.
      @(posedge clk); #1;
      a = 32'd1; b = 32'd2; sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      busy_cnt = busy ? 1 : 0;
      done_cnt = 0;
      for (int i = 1; i < 20; i++) begin
         if (i == 3) begin
            start = 1'b1; a = 32'd100; b = 32'd200;
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            chk("restart sum", 64'(sum), 64'd3);
         end
      end
      chk("restart done count", 64'(done_cnt), 64'd1);
      chk("restart busy cycles", 64'(busy_cnt), 64'd9);

      // Reset in the middle of a run (k=4).
      run_op("pre-rst", 32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;
      a = 32'h12345678; b = 32'h11111111; sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("midrst started", 64'(busy), 64'd1);
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("midrst busy", 64'(busy), 64'd0);
      chk("midrst done", 64'(done), 64'd0);
      chk("midrst sum",  64'(sum),  64'd0);
      chk("midrst cout", 64'(cout), 64'd0);
      chk("midrst ovf",  64'(ovf),  64'd0);
      done_cnt = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) done_cnt++;
      end
      rst = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done) done_cnt++;
      end
      chk("midrst no done", 64'(done_cnt), 64'd0);
      last_done = -1;
      run_op("post-rst", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0);

      // Randomised operations, issued back to back against a wide-arithmetic model.
      for (int i = 0; i < 200; i++) begin
         ra = $urandom; rb = $urandom;
         rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
         if (i % 17 == 0) rb = ra;
         bx   = rs ? ~rb : rb;
         wide = {1'b0, ra} + {1'b0, bx} + {32'd0, (rs | rc)};
         es   = wide[31:0];
         ec   = wide[32];
         eo   = (ra[31] == bx[31]) && (es[31] != ra[31]);
         run_op("rand", ra, rb, rs, rc, es, ec, eo, (es == 32'd0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
